// File: rtl/rapid_dmem_responder.sv
// Fixed-latency data-memory responder: one request in flight, byte/half/word access, address wrap.
// Optional misaligned-access trapping is enabled by defining RAPID_DMEM_MISALIGN_TRAP_EN.
module rapid_dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rw,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   localparam logic       CACHE_READ   = 1'b0;
   localparam logic       CACHE_WRITE  = 1'b1;
   localparam logic [1:0] CACHE_NOP    = 2'd0;
   localparam logic [1:0] QUARTER_WORD = 2'd1;
   localparam logic [1:0] HALF_WORD    = 2'd2;
   localparam logic [1:0] WORD         = 2'd3;

   localparam logic [1:0] RSP_IDLE = 2'd0;
   localparam logic [1:0] RSP_BUSY = 2'd1;
   localparam logic [1:0] RSP_DONE = 2'd2;

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

`ifdef RAPID_DMEM_MISALIGN_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          rw_q, rw_d;
   logic [1:0]    op_q, op_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [1:0]    off_q, off_d;
   logic [31:0]   wdata_q, wdata_d;

   logic [31:0]   mem_q [DEPTH_WORDS];

   logic          enter_done;
   logic          wr_en;
   logic [1:0]    wr_off;
   logic [3:0]    wr_mask;
   logic [31:0]   wr_data;
   logic [1:0]    rd_off;
   logic [31:0]   rd_word;
   logic [31:0]   rd_data;
   logic          mis_q;
   logic          unused_addr_hi;

   // Without trapping, misaligned halves/words are silently aligned down.
   function automatic logic [1:0] eff_off(input logic [1:0] op, input logic [1:0] off);
      case (op)
         HALF_WORD: return {off[1], 1'b0};
         WORD:      return 2'b00;
         default:   return off;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] off);
      return ((op == HALF_WORD) && off[0]) || ((op == WORD) && (off != 2'b00));
   endfunction

   function automatic logic [3:0] lane_mask(input logic [1:0] op, input logic [1:0] off);
      case (op)
         QUARTER_WORD: return 4'b0001 << off;
         HALF_WORD:    return 4'b0011 << off;
         WORD:         return 4'b1111;
         default:      return 4'b0000;
      endcase
   endfunction

   assign unused_addr_hi = &{1'b0, req_addr[31:AW+2]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rw_d    = rw_q;
      op_d    = op_q;
      idx_d   = idx_q;
      off_d   = off_q;
      wdata_d = wdata_q;
      case (state_q)
         RSP_IDLE: begin
            if (req_valid) begin
               rw_d    = req_rw;
               op_d    = req_op;
               idx_d   = req_addr[AW+1:2];
               off_d   = req_addr[1:0];
               wdata_d = req_wdata;
               cnt_d   = LAT_M1;
               state_d = (LATENCY == 1) ? RSP_DONE : RSP_BUSY;
            end
         end
         RSP_BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = RSP_DONE;
            end
         end
         RSP_DONE: state_d = RSP_IDLE;
         default:  state_d = RSP_IDLE;
      endcase
   end

   // Stores use the *_d view so a LATENCY=1 request writes on its own accept edge.
   always_comb begin
      enter_done = (state_q != RSP_DONE) && (state_d == RSP_DONE);
      wr_off     = eff_off(op_d, off_d);
      wr_mask    = lane_mask(op_d, wr_off);
      wr_data    = wdata_d << {wr_off, 3'b000};
      wr_en      = enter_done && (rw_d == CACHE_WRITE) && !(TRAP_EN && is_misaligned(op_d, off_d));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RSP_IDLE;
         cnt_q   <= 4'd0;
         rw_q    <= CACHE_READ;
         op_q    <= CACHE_NOP;
         idx_q   <= '0;
         off_q   <= 2'b00;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rw_q    <= rw_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         off_q   <= off_d;
         wdata_q <= wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_mask[b]) begin
               mem_q[idx_d][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      rd_off  = eff_off(op_q, off_q);
      rd_word = mem_q[idx_q] >> {rd_off, 3'b000};
      case (op_q)
         QUARTER_WORD: rd_data = {24'd0, rd_word[7:0]};
         HALF_WORD:    rd_data = {16'd0, rd_word[15:0]};
         WORD:         rd_data = rd_word;
         default:      rd_data = 32'd0;
      endcase
      mis_q = TRAP_EN && is_misaligned(op_q, off_q);
   end

   assign req_ready  = (state_q == RSP_IDLE);
   assign resp_valid = (state_q == RSP_DONE);
   assign resp_err   = resp_valid && mis_q;
   assign resp_rdata = (resp_valid && (rw_q == CACHE_READ) && !mis_q) ? rd_data : 32'd0;

endmodule

// File: doc/rapid_dmem_responder.md
RAPID_DMEM_RESPONDER -- requirements
Module: rapid_dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words of internal storage, power of two.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request acceptance to response, legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1: initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1: responder can accept a request this cycle.
REQ-007 SHALL have port req_rw, input, cache_rw: CACHE_READ or CACHE_WRITE.
REQ-008 SHALL have port req_op, input, cache_operation: CACHE_NOP, QUARTER_WORD (byte), HALF_WORD, or WORD.
REQ-009 SHALL have port req_addr, input, 32: byte address.
REQ-010 SHALL have port req_wdata, input, 32: store data, right-justified.
REQ-011 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 32: load data, right-justified, zero-extended.
REQ-013 SHALL have port resp_err, output, 1: access faulted; qualified by resp_valid.

Function
REQ-014 SHALL implement states RSP_IDLE, RSP_BUSY, and RSP_DONE.
REQ-015 SHALL assert req_ready only in RSP_IDLE.
REQ-016 SHALL accept a request on an edge with req_valid && req_ready, capture rw/op/addr/wdata, load a down-counter with LATENCY-1, and move to RSP_BUSY; if LATENCY=1, it SHALL move directly to RSP_DONE.
REQ-017 SHALL, in RSP_BUSY, decrement the counter each cycle and move to RSP_DONE when the counter reaches 0.
REQ-018 SHALL, in RSP_DONE, hold resp_valid high for exactly one cycle, then return to RSP_IDLE; first resp_valid SHALL occur LATENCY cycles after the accept edge; back-to-back throughput SHALL be one request per LATENCY+1 cycles.
REQ-019 SHALL form the word index from req_addr[log2(DEPTH_WORDS)+1:2], with higher address bits ignored so that addresses wrap modulo DEPTH_WORDS*4.
REQ-020 SHALL, for a read, shift the addressed word right by 8*addr[1:0] and mask it to 8, 16, or 32 bits per req_op; upper bits SHALL be 0 (the MEM stage performs sign extension).
REQ-021 SHALL, for a write, update only the byte lanes selected by op and addr[1:0] (byte: 1 lane; half: lanes addr[1:0] and addr[1:0]+1; word: all 4), using the low bits of req_wdata; the update SHALL commit on the edge entering RSP_DONE.
REQ-022 SHALL, for CACHE_NOP, follow the same timing, cause no memory effect, and return resp_rdata=0 and resp_err=0.
REQ-023 SHALL hold resp_rdata and resp_err at 0 whenever resp_valid=0.
REQ-024 SHALL, when a write and a read target the same word on consecutive requests, return the newly written data on the read.
REQ-025 SHALL ignore req_valid while not in RSP_IDLE and SHALL NOT latch any request inputs then.

Reset
REQ-026 SHALL, on rst assertion, immediately force state to RSP_IDLE, counter to 0, req_ready=1 after release, resp_valid=0, resp_rdata=0, and resp_err=0.
REQ-027 SHALL, if rst is asserted mid-operation, abort the in-flight request with no write committed and no response issued.
REQ-028 SHALL NOT clear storage contents on reset; contents are undefined until written.

Configuration
REQ-029 SHALL support macro RAPID_DMEM_MISALIGN_TRAP_EN; when defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL complete with normal timing, resp_err=1, resp_rdata=0, and no write.
REQ-030 SHALL, when RAPID_DMEM_MISALIGN_TRAP_EN is undefined, force-align misaligned accesses (half: clear addr[0]; word: clear addr[1:0]), complete them normally, and hold resp_err constantly 0.

Verification
REQ-031 SHALL cover: LATENCY=2, WORD write 0xDEADBEEF to 0x10, then WORD read of 0x10 -> resp_valid exactly 2 cycles after each accept, rdata=0xDEADBEEF, req_ready low in between.
REQ-032 SHALL cover: after REQ-031, QUARTER_WORD write 0xA5 to 0x12, then WORD read of 0x10 -> 0xDEA5BEEF; QUARTER_WORD read of 0x13 -> 0x000000DE.
REQ-033 SHALL cover: HALF_WORD read of 0x11 -> with RAPID_DMEM_MISALIGN_TRAP_EN: err=1, rdata=0; without it: err=0, rdata=0x0000BEEF (force-aligned to 0x10).
REQ-034 SHALL cover: DEPTH_WORDS=256, WORD write 0x11223344 to 0x400, then WORD read of 0x000 -> 0x11223344 (wrap-around).
REQ-035 SHALL cover: WORD write 0x0 to 0x20 accepted, rst pulsed one cycle later, then WORD read of 0x20 -> old contents, with no resp_valid for the aborted write.
REQ-036 SHALL cover: CACHE_NOP with req_valid held high for 10 cycles -> one accept per LATENCY+1 cycles, rdata=0, memory unchanged.
